// File: rtl/tm_queue.sv
// tm_queue: per-output-port header queues between the last pipeline stage and egress.
// Each accepted header is copied into every queue selected by its destination bitmap, so multicast
// fans out here. A single registered output stage drains the queues round-robin, one header per cycle.
// Optional feature macro: TM_DROP_EN. When it is defined, the input never backpressures: full queues
// are skipped and a saturating drop counter is kept. When it is undefined, the input stalls instead.

`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 4
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif

module tm_queue #(
  parameter int unsigned NUM_PORTS = `NUM_PORTS,
  parameter int unsigned HDR_LEN   = `HDR_MAX_LEN,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     tm_in_valid_i,
  output logic                                     tm_in_ready_o,
  input  logic [NUM_PORTS-1:0]                     tm_out_port_i,
  input  logic [HDR_LEN*`BYTE_BUS-1:0]             tm_pkt_hdr_i,
  output logic                                     tm_out_valid_o,
  input  logic                                     tm_out_ready_i,
  output logic [NUM_PORTS-1:0]                     tm_out_port_o,
  output logic [HDR_LEN*`BYTE_BUS-1:0]             tm_pkt_hdr_o,
`ifdef TM_DROP_EN
  output logic [NUM_PORTS*$clog2(DEPTH+1)-1:0]     tm_q_count_o,
  output logic [CNT_W-1:0]                         tm_drop_cnt_o
`else
  output logic [NUM_PORTS*$clog2(DEPTH+1)-1:0]     tm_q_count_o
`endif
);

  localparam int unsigned HW = HDR_LEN * `BYTE_BUS;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(NUM_PORTS);

  // Elaboration-time sanity checks on the configuration.
  if (NUM_PORTS < 2) begin : g_bad_ports
    $error("tm_queue: NUM_PORTS must be >= 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tm_queue: DEPTH must be a power of 2 and >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("tm_queue: CNT_W must be >= 1");
  end

  typedef enum logic [0:0] {StEmpty, StHold} out_state_e;

  logic [HW-1:0]        mem_q    [NUM_PORTS][DEPTH];
  logic [AW-1:0]        wr_ptr_q [NUM_PORTS];
  logic [AW-1:0]        rd_ptr_q [NUM_PORTS];
  logic [CW-1:0]        count_q  [NUM_PORTS];

  out_state_e           state_q;
  logic [NUM_PORTS-1:0] port_q;
  logic [HW-1:0]        hdr_q;
  logic [PW-1:0]        rr_q;

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] nonempty;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic                 accept;
  logic                 load;
  logic                 pick_found;
  logic [PW-1:0]        pick_idx;
  int unsigned          cand;

  // Queue status flags from registered counts only (no pop bypass).
  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      full[p]     = (count_q[p] == CW'(DEPTH));
      nonempty[p] = (count_q[p] != '0);
    end
  end

`ifdef TM_DROP_EN
  assign tm_in_ready_o = 1'b1;
`else
  assign tm_in_ready_o = ~|(tm_out_port_i & full);
`endif

  assign accept = tm_in_valid_i & tm_in_ready_o;
  // Without drop mode an accepted header never targets a full queue, so the mask is a no-op there.
  assign push   = accept ? (tm_out_port_i & ~full) : '0;
  assign load   = (state_q == StEmpty) | tm_out_ready_i;

  // Round-robin pick: first non-empty queue scanning rr+1, rr+2, ... modulo NUM_PORTS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!pick_found && nonempty[PW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

  // One-hot pop of the picked queue whenever the output register reloads.
  always_comb begin
    pop = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      pop[p] = load & pick_found & (pick_idx == PW'(p));
    end
  end

  // Header storage; contents need no reset since counts gate every read.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) mem_q[p][wr_ptr_q[p]] <= tm_pkt_hdr_i;
    end
  end

  // Per-queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + AW'(1);
        if (pop[p])  rd_ptr_q[p] <= rd_ptr_q[p] + AW'(1);
        if (push[p] && !pop[p])      count_q[p] <= count_q[p] + CW'(1);
        else if (!push[p] && pop[p]) count_q[p] <= count_q[p] - CW'(1);
      end
    end
  end

  // Output stage FSM: reload on EMPTY or on a consumed HOLD, otherwise keep the held header.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      port_q  <= '0;
      hdr_q   <= '0;
      rr_q    <= PW'(NUM_PORTS - 1);
    end else if (load) begin
      if (pick_found) begin
        state_q <= StHold;
        port_q  <= pop;
        hdr_q   <= mem_q[pick_idx][rd_ptr_q[pick_idx]];
        rr_q    <= pick_idx;
      end else begin
        state_q <= StEmpty;
      end
    end
  end

  assign tm_out_valid_o = (state_q == StHold);
  assign tm_out_port_o  = port_q;
  assign tm_pkt_hdr_o   = hdr_q;

  // Flatten per-queue occupancy onto the count bus, queue 0 in the low bits.
  always_comb begin
    tm_q_count_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      tm_q_count_o[p*CW +: CW] = count_q[p];
    end
  end

`ifdef TM_DROP_EN
  localparam int unsigned SW = CNT_W + PW + 1;

  logic [CNT_W-1:0]     drop_q;
  logic [NUM_PORTS-1:0] skipped;
  logic [PW:0]          nskip;
  logic [SW-1:0]        drop_sum;

  // Number of selected queues that were full at accept time, added with saturation.
  always_comb begin
    skipped = accept ? (tm_out_port_i & full) : '0;
    nskip   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      nskip = nskip + (PW+1)'(skipped[p]);
    end
    drop_sum = SW'(drop_q) + SW'(nskip);
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (drop_sum > SW'({CNT_W{1'b1}})) begin
      drop_q <= {CNT_W{1'b1}};
    end else begin
      drop_q <= drop_sum[CNT_W-1:0];
    end
  end

  assign tm_drop_cnt_o = drop_q;
`endif

endmodule

// File: tb/tb_tm_queue.sv
// Directed bench for tm_queue with NUM_PORTS=4, HDR_LEN=4 bytes, DEPTH=4.
// Builds with or without TM_DROP_EN; only the full-queue scenario and drop counter differ.

module tb_tm_queue;

  localparam int NP = 4;
  localparam int HL = 4;
  localparam int DP = 4;
  localparam int CW = 3;
  localparam int HW = HL * 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NP-1:0]     in_port;
  logic [HW-1:0]     in_hdr;
  logic              out_valid;
  logic              out_ready;
  logic [NP-1:0]     out_port;
  logic [HW-1:0]     out_hdr;
  logic [NP*CW-1:0]  q_count;
`ifdef TM_DROP_EN
  logic [15:0]       drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  tm_queue #(
    .NUM_PORTS(NP),
    .HDR_LEN  (HL),
    .DEPTH    (DP),
    .CNT_W    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tm_in_valid_i (in_valid),
    .tm_in_ready_o (in_ready),
    .tm_out_port_i (in_port),
    .tm_pkt_hdr_i  (in_hdr),
    .tm_out_valid_o(out_valid),
    .tm_out_ready_i(out_ready),
    .tm_out_port_o (out_port),
    .tm_pkt_hdr_o  (out_hdr),
`ifdef TM_DROP_EN
    .tm_q_count_o  (q_count),
    .tm_drop_cnt_o (drop_cnt)
`else
    .tm_q_count_o  (q_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] qc(input int p);
    return q_count[p*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Offer one header and wait (bounded) until it is accepted at a clock edge.
  task automatic push(input logic [NP-1:0] port, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_port  = port;
    in_hdr   = {24'h0, b};
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq("push_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  logic [NP-1:0] rr_port [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
  logic [7:0]    rr_hdr  [6] = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_port   = '0;
    in_hdr    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    in_port = 4'b1111;
    #1;

    // Reset state
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_port", out_port, '0);
    check_eq("rst_hdr", out_hdr, '0);
    check_eq("rst_ready", in_ready, 1'b1);
    check_eq("rst_counts", q_count, '0);
`ifdef TM_DROP_EN
    check_eq("rst_drop", drop_cnt, '0);
`endif

    // Bitmap 0: accepted and discarded
    in_valid = 1'b1;
    in_port  = 4'b0000;
    in_hdr   = 32'hFF;
    #1;
    check_eq("zero_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_eq("zero_counts", q_count, '0);
    tick();
    check_eq("zero_valid", out_valid, 1'b0);

    // Unicast to port 1
    out_ready = 1'b1;
    push(4'b0010, 8'hA5);
    check_eq("uni_count", qc(1), 3'd1);
    check_eq("uni_valid_e", out_valid, 1'b0);
    tick();
    check_eq("uni_valid", out_valid, 1'b1);
    check_eq("uni_port", out_port, 4'b0010);
    check_eq("uni_hdr", out_hdr, 32'hA5);
    check_eq("uni_count0", qc(1), 3'd0);
    tick();
    check_eq("uni_drain", out_valid, 1'b0);

    // Multicast to ports 0 and 2 after reset (rr points at port 3)
    do_reset();
    out_ready = 1'b1;
    push(4'b0101, 8'h3C);
    check_eq("mc_cnt0", qc(0), 3'd1);
    check_eq("mc_cnt2", qc(2), 3'd1);
    tick();
    check_eq("mc_v1", out_valid, 1'b1);
    check_eq("mc_p1", out_port, 4'b0001);
    check_eq("mc_h1", out_hdr, 32'h3C);
    tick();
    check_eq("mc_v2", out_valid, 1'b1);
    check_eq("mc_p2", out_port, 4'b0100);
    check_eq("mc_h2", out_hdr, 32'h3C);
    tick();
    check_eq("mc_drain", out_valid, 1'b0);

    // Round-robin: first header goes straight to the output register while the rest queue up
    do_reset();
    out_ready = 1'b0;
    push(4'b0001, 8'h10);
    push(4'b0010, 8'h20);
    push(4'b0100, 8'h30);
    push(4'b0001, 8'h11);
    push(4'b0010, 8'h21);
    push(4'b0100, 8'h31);
    check_eq("rr_cnt0", qc(0), 3'd1);
    check_eq("rr_cnt1", qc(1), 3'd2);
    check_eq("rr_cnt2", qc(2), 3'd2);
    for (int s = 0; s < 3; s++) begin
      tick();
      check_eq("stall_valid", out_valid, 1'b1);
      check_eq("stall_port", out_port, 4'b0001);
      check_eq("stall_hdr", out_hdr, 32'h10);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check_eq("rr_valid", out_valid, 1'b1);
      check_eq("rr_port", out_port, rr_port[k]);
      check_eq("rr_hdr", out_hdr, {24'h0, rr_hdr[k]});
      tick();
    end
    check_eq("rr_drain", out_valid, 1'b0);

    // Full queue: park a port-1 header in the output register, then fill queue 0
    do_reset();
    out_ready = 1'b0;
    push(4'b0010, 8'h4F);
    for (int k = 0; k < 4; k++) push(4'b0001, 8'h50 + 8'(k));
    check_eq("full_cnt", qc(0), 3'd4);
    check_eq("full_oport", out_port, 4'b0010);
    check_eq("full_ohdr", out_hdr, 32'h4F);
    in_valid = 1'b1;
    in_port  = 4'b0001;
    in_hdr   = 32'h54;
    #1;
`ifdef TM_DROP_EN
    check_eq("drop_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_eq("drop_cnt_q", qc(0), 3'd4);
    check_eq("drop_cnt", drop_cnt, 16'd1);
    check_eq("drop_ohdr", out_hdr, 32'h4F);
`else
    check_eq("full_ready", in_ready, 1'b0);
    tick();
    check_eq("full_ready2", in_ready, 1'b0);
    check_eq("full_cnt2", qc(0), 3'd4);
    tick();
    check_eq("full_ready3", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("full_popcnt", qc(0), 3'd3);
    check_eq("full_ready4", in_ready, 1'b1);
    check_eq("full_pport", out_port, 4'b0001);
    check_eq("full_phdr", out_hdr, 32'h50);
    tick();
    in_valid = 1'b0;
    check_eq("full_refill", qc(0), 3'd4);
    check_eq("full_hold", out_hdr, 32'h50);
`endif

    // Mid-stream asynchronous reset flushes everything
    #2;
    rst = 1'b0;
    #1;
    check_eq("mrst_counts", q_count, '0);
    check_eq("mrst_valid", out_valid, 1'b0);
    check_eq("mrst_port", out_port, '0);
    check_eq("mrst_hdr", out_hdr, '0);
`ifdef TM_DROP_EN
    check_eq("mrst_drop", drop_cnt, '0);
`endif
    tick();
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
